booth_radix4_mult: RTL and testbench

- Self-contained sequential signed multiplier using radix-4 (modified Booth) recoding, parametrised in operand width.
- Datapath and controller are merged into one block, with a start/busy/done handshake and a synchronous abort.
- Processes 2 multiplier bits per cycle, so one operation takes WIDTH/2 iteration cycles instead of WIDTH.
- Drop-in arithmetic unit for datapaths that need an N-bit signed multiply.

---
 rtl/booth_radix4_mult.sv | 117 +++++++++++
 tb/tb_booth_radix4_mult.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_mult.sv
// Sequential signed multiplier using radix-4 (modified Booth) recoding.
// Retires two multiplier bits per cycle behind a start/busy/done handshake with abort.
module booth_radix4_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int AW = WIDTH + 2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $fatal(1, "booth_radix4_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_m;
    logic [AW-1:0]        r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_qm1;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [AW-1:0]        w_m2;
    logic [AW-1:0]        w_m_neg;
    logic [AW-1:0]        w_m2_neg;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_sum;
    logic [AW+WIDTH:0]    w_shifted;
    logic [AW-1:0]        w_a_new;
    logic [WIDTH-1:0]     w_q_new;
    logic                 w_qm1_new;

    assign w_m2     = {r_m[AW-2:0], 1'b0};
    assign w_m_neg  = (~r_m) + AW'(1);
    assign w_m2_neg = (~w_m2) + AW'(1);

    // Booth digit from the overlapping triplet {Q[1],Q[0],q_m1}
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = w_m2_neg;
            3'b101, 3'b110: w_addend = w_m_neg;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum     = r_a + w_addend;
    assign w_shifted = {{2{w_sum[AW-1]}}, w_sum, r_q, r_qm1} >> 2;
    assign w_a_new   = w_shifted[AW+WIDTH:WIDTH+1];
    assign w_q_new   = w_shifted[WIDTH:1];
    assign w_qm1_new = w_shifted[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= {{2{a[WIDTH-1]}}, a};
                        r_a     <= '0;
                        r_q     <= b;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CNT_W'(WIDTH/2);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // abort wins even over the final iteration
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_a   <= w_a_new;
                        r_q   <= w_q_new;
                        r_qm1 <= w_qm1_new;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_product <= {w_a_new[WIDTH-1:0], w_q_new};
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_RUN) || (r_state == S_DONE);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult: directed scenarios at WIDTH=8 and
// a scoreboard-driven random sweep run in parallel at WIDTH=8, 16 and 6.
module tb_booth_radix4_mult;
    localparam int N_SWEEP = 3000;

    logic clk;
    logic rst_n;

    logic        start8, abort8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        start16, abort16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    logic        start6, abort6, busy6, done6;
    logic [5:0]  a6, b6;
    logic [11:0] prod6;

    int checks;
    int errors;

    logic [15:0] q8[$];
    logic [31:0] q16[$];
    logic [11:0] q6[$];
    logic [15:0] m_prod8;

    booth_radix4_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_radix4_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    booth_radix4_mult #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6),
        .a(a6), .b(b6), .busy(busy6), .done(done6), .product(prod6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        longint px, py;
        px = longint'($signed(x));
        py = longint'($signed(y));
        return 16'(px * py);
    endfunction

    // Pushes the expected product, pulses start for one cycle and waits for done.
    // lat counts falling edges from the drive edge to the one where done is seen.
    task automatic drive_op8(input logic [7:0] ia, input logic [7:0] ib,
                             output int lat, output logic got);
        q8.push_back(ref8(ia, ib));
        @(negedge clk);
        a8 = ia; b8 = ib; start8 = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            start8 = 1'b0;
            got = done8;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 0; abort8 = 0; a8 = '0; b8 = '0;
        start16 = 0; abort16 = 0; a16 = '0; b16 = '0;
        start6 = 0; abort6 = 0; a6 = '0; b6 = '0;
        m_prod8 = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL reset_flags8 busy=%b done=%b expected 0 0", busy8, done8); end
        checks++; if (prod8 !== 16'h0) begin errors++; $display("FAIL reset_prod8 got=%h expected=0000", prod8); end
        checks++; if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0) begin errors++; $display("FAIL reset_dut16 busy=%b done=%b prod=%h expected 0", busy16, done16, prod16); end
        checks++; if (busy6 !== 1'b0 || done6 !== 1'b0 || prod6 !== 12'h0) begin errors++; $display("FAIL reset_dut6 busy=%b done=%b prod=%h expected 0", busy6, done6, prod6); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy8 !== 1'b0 || prod8 !== 16'h0) begin errors++; $display("FAIL reset_release_idle busy=%b prod=%h expected 0 0000", busy8, prod8); end
        $display("test_reset: done");
    endtask

    task automatic test_basic;
        int busy_cnt, done_cnt, done_at;
        logic [15:0] exp;
        busy_cnt = 0; done_cnt = 0; done_at = 0; exp = 'x;
        q8.push_back(ref8(8'd7, 8'd3));
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd3; start8 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                done_at = i;
                exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
                checks++; if (prod8 !== exp) begin errors++; $display("FAIL basic_product got=%h expected=%h", prod8, exp); end
                m_prod8 = exp;
            end
        end
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles got=%0d expected=5", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d expected=1", done_cnt); end
        checks++; if (done_at != 5) begin errors++; $display("FAIL basic_latency got=%0d expected=5", done_at); end
        checks++; if (prod8 !== 16'h0015) begin errors++; $display("FAIL basic_held got=%h expected=0015", prod8); end
        $display("test_basic: 7*3 product=%h busy_cycles=%0d dones=%0d", prod8, busy_cnt, done_cnt);
    endtask

    task automatic test_corners;
        logic [7:0] ca [3];
        logic [7:0] cb [3];
        int lat;
        logic got;
        logic [15:0] exp;
        ca = '{8'h80, 8'h80, 8'hFF};
        cb = '{8'h80, 8'h7F, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            drive_op8(ca[i], cb[i], lat, got);
            exp = q8.pop_front();
            checks++; if (!got || lat != 5) begin errors++; $display("FAIL corner_latency a=%h b=%h got=%0d expected=5", ca[i], cb[i], lat); end
            checks++; if (prod8 !== exp) begin errors++; $display("FAIL corner_product a=%h b=%h got=%h expected=%h", ca[i], cb[i], prod8, exp); end
            m_prod8 = exp;
            $display("test_corners: a=%h b=%h product=%h expected=%h", ca[i], cb[i], prod8, exp);
        end
    endtask

    task automatic test_back_to_back;
        int done_cnt, busy_cnt, last_done, bad_gap;
        logic [15:0] exp;
        done_cnt = 0; busy_cnt = 0; last_done = 0; bad_gap = 0;
        repeat (5) q8.push_back(ref8(8'h00, 8'hB3));
        @(negedge clk);
        a8 = 8'h00; b8 = 8'hB3; start8 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (i - last_done != ((last_done == 0) ? 5 : 6)) bad_gap++;
                last_done = i;
                exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
                checks++; if (prod8 !== exp) begin errors++; $display("FAIL b2b_product got=%h expected=%h", prod8, exp); end
                m_prod8 = exp;
            end
        end
        start8 = 1'b0;
        checks++; if (done_cnt != 5) begin errors++; $display("FAIL b2b_done_pulses got=%0d expected=5", done_cnt); end
        checks++; if (busy_cnt != 25) begin errors++; $display("FAIL b2b_busy_cycles got=%0d expected=25", busy_cnt); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_interval bad_gaps=%0d expected=0", bad_gap); end
        q8.delete();
        $display("test_back_to_back: dones=%0d busy_cycles=%0d", done_cnt, busy_cnt);
    endtask

    task automatic test_abort;
        logic [15:0] prev, exp;
        logic done_seen, got;
        int lat;
        prev = m_prod8;
        done_seen = 1'b0;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_to_idle busy=%b expected=0", busy8); end
        if (done8) done_seen = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done8) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done done_seen=%b expected=0", done_seen); end
        checks++; if (prod8 !== prev) begin errors++; $display("FAIL abort_prod_kept got=%h expected=%h", prod8, prev); end
        drive_op8(8'd5, 8'd5, lat, got);
        exp = q8.pop_front();
        checks++; if (!got || prod8 !== exp) begin errors++; $display("FAIL abort_restart got=%h expected=%h done=%b", prod8, exp, got); end
        m_prod8 = exp;
        $display("test_abort: held=%h restart product=%h", prev, prod8);
    endtask

    task automatic test_async_reset;
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'hFD; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL async_reset_flags busy=%b done=%b expected 0 0", busy8, done8); end
        checks++; if (prod8 !== 16'h0) begin errors++; $display("FAIL async_reset_prod got=%h expected=0000", prod8); end
        q8.delete();
        m_prod8 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy8 || done8) busy_cnt++;
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL async_reset_stays_idle active_cycles=%0d expected=0", busy_cnt); end
        $display("test_async_reset: product=%h after reset", prod8);
    endtask

    task automatic test_random_sweep;
        int err_before;
        err_before = errors;
        fork
            begin : lane8
                for (int n = 0; n < N_SWEEP; n++) begin
                    logic [7:0] ra, rb;
                    logic [15:0] exp;
                    int lat;
                    logic got;
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    drive_op8(ra, rb, lat, got);
                    exp = q8.pop_front();
                    checks++; if (!got || lat != 5) begin errors++; $display("FAIL sweep8_latency a=%h b=%h got=%0d expected=5", ra, rb, lat); end
                    checks++; if (got && prod8 !== exp) begin errors++; $display("FAIL sweep8_product a=%h b=%h got=%h expected=%h", ra, rb, prod8, exp); end
                    m_prod8 = exp;
                end
            end
            begin : lane16
                for (int n = 0; n < N_SWEEP; n++) begin
                    logic [15:0] ra, rb;
                    logic [31:0] exp;
                    longint pa, pb;
                    int lat;
                    logic got;
                    ra = (n < 2) ? 16'h8000 : 16'($urandom);
                    rb = (n == 0) ? 16'h8000 : (n == 1) ? 16'h7FFF : 16'($urandom);
                    pa = longint'($signed(ra));
                    pb = longint'($signed(rb));
                    q16.push_back(32'(pa * pb));
                    @(negedge clk);
                    a16 = ra; b16 = rb; start16 = 1'b1;
                    lat = 0; got = 1'b0;
                    while (!got && lat < 20) begin
                        @(negedge clk);
                        lat++;
                        start16 = 1'b0;
                        got = done16;
                    end
                    exp = q16.pop_front();
                    checks++; if (!got || lat != 9) begin errors++; $display("FAIL sweep16_latency a=%h b=%h got=%0d expected=9", ra, rb, lat); end
                    checks++; if (got && prod16 !== exp) begin errors++; $display("FAIL sweep16_product a=%h b=%h got=%h expected=%h", ra, rb, prod16, exp); end
                end
            end
            begin : lane6
                for (int n = 0; n < N_SWEEP; n++) begin
                    logic [5:0] ra, rb;
                    logic [11:0] exp;
                    longint pa, pb;
                    int lat;
                    logic got;
                    ra = (n < 2) ? 6'h20 : 6'($urandom);
                    rb = (n == 0) ? 6'h20 : (n == 1) ? 6'h1F : 6'($urandom);
                    pa = longint'($signed(ra));
                    pb = longint'($signed(rb));
                    q6.push_back(12'(pa * pb));
                    @(negedge clk);
                    a6 = ra; b6 = rb; start6 = 1'b1;
                    lat = 0; got = 1'b0;
                    while (!got && lat < 20) begin
                        @(negedge clk);
                        lat++;
                        start6 = 1'b0;
                        got = done6;
                    end
                    exp = q6.pop_front();
                    checks++; if (!got || lat != 4) begin errors++; $display("FAIL sweep6_latency a=%h b=%h got=%0d expected=4", ra, rb, lat); end
                    checks++; if (got && prod6 !== exp) begin errors++; $display("FAIL sweep6_product a=%h b=%h got=%h expected=%h", ra, rb, prod6, exp); end
                end
            end
        join
        $display("test_random_sweep: %0d pairs per width, %0d new errors", N_SWEEP, errors - err_before);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
